mem_wb_pipe: RTL and testbench
==============================

Name: mem_wb_pipe

Overview:
Parametrised MEM/WB pipeline stage register with valid/ready handshake, flush and an optional 2-entry skid buffer. It carries memory read data, ALU result, destination register and WB control bits from MEM to the register-file write port. It adds per-stage back-pressure, bubble insertion, $zero write suppression and a precomputed writeback value.

Parameters:
DATA_W, 32, width of data and ALU result paths
REG_W, 5, width of destination register index
SKID, 1, 1 = 2-entry skid buffer (registered ready); 0 = single register (combinational ready)
CNT_W, 16, stall counter width (optional feature only)

Ports:
clk_mem_wb_pipe  in  1  clock, rising edge
rst_mem_wb_pipe  in  1  synchronous reset, active-high
valid_IN  in  1  upstream entry valid
ready_OUT  out  1  stage can accept an entry
data_IN  in  DATA_W  memory read data
resALU_IN  in  DATA_W  ALU result
regDst_IN  in  REG_W  destination register (RegDst mux output)
WB_IN  in  2  [1]=RegWrite, [0]=MemtoReg
flush_IN  in  1  discard all held and incoming entries
valid_OUT  out  1  output entry valid
ready_IN  in  1  downstream accepts
data_OUT  out  DATA_W  registered memory data
resALU_OUT  out  DATA_W  registered ALU result
regDst_OUT  out  REG_W  registered destination
RegWrite_OUT  out  1  register-file write enable, gated
MemtoReg_OUT  out  1  registered MemtoReg
wbValue_OUT  out  DATA_W  MemtoReg_OUT ? data_OUT : resALU_OUT
stallCount_OUT  out  CNT_W  present only with MEM_WB_STALL_CNT_EN

Behaviour:
- in_fire = valid_IN & ready_OUT; out_fire = valid_OUT & ready_IN.
- Latency: an entry accepted on edge N appears on the outputs after edge N; 1 cycle.
- Reset: all valid bits 0; data_OUT, resALU_OUT, regDst_OUT, MemtoReg_OUT, wbValue_OUT 0; RegWrite_OUT 0; skid entry cleared. ready_OUT is 1 the cycle after reset. Inputs are ignored while reset is high. Reset mid-transfer drops all entries.
- At capture, the stored RegWrite = WB_IN[1] & (regDst_IN != 0). Writes to $zero are never issued.
- RegWrite_OUT = valid_OUT & stored RegWrite. A bubble never writes.
- Payload fields hold their last value while invalid. Only valid and RegWrite are cleared.
- SKID=1 state machine (main entry M, skid entry S):
  - EMPTY (M invalid): ready_OUT=1. in_fire -> ONE, M <= input.
  - ONE (M valid, S empty): ready_OUT=1.
    - in_fire & out_fire -> ONE, M <= input.
    - in_fire & !out_fire -> FULL, S <= input.
    - !in_fire & out_fire -> EMPTY.
  - FULL: ready_OUT=0. out_fire -> ONE, M <= S. Otherwise hold.
  - ready_OUT = !S.valid, driven from a register (no combinational path from ready_IN).
- SKID=0: single entry M. ready_OUT = ready_IN | !valid_OUT (combinational).
  - in_fire -> M <= input.
  - out_fire & !in_fire -> M invalid.
- Order is preserved. No entry is dropped or duplicated under any valid/ready pattern.
- flush_IN=1: next state EMPTY, both valid bits 0. A simultaneous in_fire is discarded. Flush overrides any in_fire or out_fire in the same cycle. Downstream sees valid_OUT=0 from the next cycle.
- Flush while reset is high: reset takes precedence; the result is identical.

Optional Feature:
MEM_WB_STALL_CNT_EN
- Defined:
  - stallCount_OUT increments each cycle with valid_OUT=1 & ready_IN=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; unaffected by flush.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- SKID=1, ready_IN=1: stream resALU_IN 0x10,0x20,0x30 with WB_IN=2'b10, regDst=5 -> same values out 1 cycle later; RegWrite_OUT=1; wbValue_OUT=resALU; ready_OUT stays 1.
- SKID=1, ready_IN=0, push A=0x11, B=0x22 -> ready_OUT=0 after B. Raise ready_IN -> A then B delivered in order; ready_OUT returns to 1 the cycle after A leaves.
- regDst_IN=0 with WB_IN=2'b11, data_IN=0xDEAD -> RegWrite_OUT=0, wbValue_OUT=0xDEAD, valid_OUT=1.
- FULL state, then flush_IN=1 with valid_IN=1 -> next cycle valid_OUT=0, RegWrite_OUT=0, ready_OUT=1; flushed input never appears.
- Reset asserted while ONE -> next cycle all outputs 0, valid_OUT=0; MEM_WB_STALL_CNT_EN build: 3 stall cycles -> stallCount_OUT=3; CNT_W=2 and 5 stalls -> 3.
- SKID=0: ready_IN toggled every cycle with continuous valid_IN -> ready_OUT tracks ready_IN | !valid_OUT combinationally; no loss or duplication over 8 entries.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB pipeline stage register with valid/ready handshake,
// flush, $zero write suppression and a precomputed writeback value.
// SKID=1 gives a 2-entry skid buffer with registered ready; SKID=0 gives a
// single entry with combinational ready.
// Optional build macro MEM_WB_STALL_CNT_EN adds a saturating stall counter
// on stallCount_OUT.
module mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_mem_wb_pipe,
  input  logic              rst_mem_wb_pipe,
  input  logic              valid_IN,
  output logic              ready_OUT,
  input  logic [DATA_W-1:0] data_IN,
  input  logic [DATA_W-1:0] resALU_IN,
  input  logic [REG_W-1:0]  regDst_IN,
  input  logic [1:0]        WB_IN,
  input  logic              flush_IN,
  output logic              valid_OUT,
  input  logic              ready_IN,
  output logic [DATA_W-1:0] data_OUT,
  output logic [DATA_W-1:0] resALU_OUT,
  output logic [REG_W-1:0]  regDst_OUT,
  output logic              RegWrite_OUT,
  output logic              MemtoReg_OUT,
  output logic [DATA_W-1:0] wbValue_OUT
`ifdef MEM_WB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stallCount_OUT
`endif
);

  if (DATA_W < 1 || REG_W < 1 || CNT_W < 1 || SKID > 1) begin : g_bad_param
    $error("mem_wb_pipe: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  rd;
    logic              rw;
    logic              m2r;
    logic [DATA_W-1:0] wb;
  } entry_t;

  state_e state_q, state_d;
  entry_t m_q, m_d;
  entry_t s_q, s_d;
  logic   ready_q, ready_d;
  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_fire  = valid_IN & ready_OUT;
  assign out_fire = valid_OUT & ready_IN;

  // Capture-side formatting: suppress $zero writes, precompute writeback value
  always_comb begin
    in_entry      = '0;
    in_entry.data = data_IN;
    in_entry.alu  = resALU_IN;
    in_entry.rd   = regDst_IN;
    in_entry.rw   = WB_IN[1] & (regDst_IN != '0);
    in_entry.m2r  = WB_IN[0];
    in_entry.wb   = WB_IN[0] ? data_IN : resALU_IN;
  end

  // State, entry and registered-ready flops
  always_ff @(posedge clk_mem_wb_pipe) begin
    if (rst_mem_wb_pipe) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      ready_q <= ready_d;
    end
  end

  // Next-state: skid FSM or single-entry occupancy; flush forces EMPTY
  always_comb begin
    state_d = state_q;
    if (SKID != 0) begin
      unique case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire) state_d = ST_FULL;
          else if (!in_fire && out_fire) state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end else begin
      if (in_fire) state_d = ST_ONE;
      else if (out_fire) state_d = ST_EMPTY;
    end
    if (flush_IN) state_d = ST_EMPTY;
    // ready is registered from the next state so ready_IN never reaches ready_OUT
    ready_d = (state_d != ST_FULL);
  end

  // Entry payload moves; payload holds while invalid, flush discards the input
  always_comb begin
    m_d = m_q;
    s_d = s_q;
    if (!flush_IN) begin
      if (SKID != 0) begin
        if (in_fire && (state_q == ST_EMPTY || (state_q == ST_ONE && out_fire)))
          m_d = in_entry;
        else if (in_fire && state_q == ST_ONE)
          s_d = in_entry;
        else if (state_q == ST_FULL && out_fire)
          m_d = s_q;
      end else begin
        if (in_fire) m_d = in_entry;
      end
    end
  end

  // Output drive: bubbles never write the register file
  always_comb begin
    valid_OUT    = (state_q != ST_EMPTY);
    ready_OUT    = (SKID != 0) ? ready_q : (ready_IN | ~valid_OUT);
    data_OUT     = m_q.data;
    resALU_OUT   = m_q.alu;
    regDst_OUT   = m_q.rd;
    RegWrite_OUT = valid_OUT & m_q.rw;
    MemtoReg_OUT = m_q.m2r;
    wbValue_OUT  = m_q.wb;
  end

`ifdef MEM_WB_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where a valid entry is held back
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_OUT && !ready_IN && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall counter flop, cleared by reset only
  always_ff @(posedge clk_mem_wb_pipe) begin
    if (rst_mem_wb_pipe) stall_cnt_q <= '0;
    else                 stall_cnt_q <= stall_cnt_d;
  end

  assign stallCount_OUT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe: SKID=1 instance (a_*),
// SKID=0 instance (b_*), and with MEM_WB_STALL_CNT_EN a CNT_W=2 instance.
module tb_mem_wb_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_vec;
  int   n_err;

  logic        a_valid_in, a_ready_out, a_flush, a_valid_out, a_ready_in;
  logic        a_rw_out, a_m2r_out;
  logic [31:0] a_data_in, a_alu_in, a_data_out, a_alu_out, a_wb_out;
  logic [4:0]  a_rd_in, a_rd_out;
  logic [1:0]  a_wb_in;

  logic        b_valid_in, b_ready_out, b_flush, b_valid_out, b_ready_in;
  logic        b_rw_out, b_m2r_out;
  logic [31:0] b_data_in, b_alu_in, b_data_out, b_alu_out, b_wb_out;
  logic [4:0]  b_rd_in, b_rd_out;
  logic [1:0]  b_wb_in;

`ifdef MEM_WB_STALL_CNT_EN
  logic [15:0] a_cnt, b_cnt;
  logic [1:0]  sat_cnt;
  logic        sat_ready_out, sat_valid_out, sat_rw_out, sat_m2r_out;
  logic [31:0] sat_data_out, sat_alu_out, sat_wb_out;
  logic [4:0]  sat_rd_out;
`endif

  mem_wb_pipe #(.DATA_W(32), .REG_W(5), .SKID(1), .CNT_W(16)) u_dut_skid (
    .clk_mem_wb_pipe(clk), .rst_mem_wb_pipe(rst),
    .valid_IN(a_valid_in), .ready_OUT(a_ready_out),
    .data_IN(a_data_in), .resALU_IN(a_alu_in), .regDst_IN(a_rd_in), .WB_IN(a_wb_in),
    .flush_IN(a_flush), .valid_OUT(a_valid_out), .ready_IN(a_ready_in),
    .data_OUT(a_data_out), .resALU_OUT(a_alu_out), .regDst_OUT(a_rd_out),
    .RegWrite_OUT(a_rw_out), .MemtoReg_OUT(a_m2r_out), .wbValue_OUT(a_wb_out)
`ifdef MEM_WB_STALL_CNT_EN
    , .stallCount_OUT(a_cnt)
`endif
  );

  mem_wb_pipe #(.DATA_W(32), .REG_W(5), .SKID(0), .CNT_W(16)) u_dut_single (
    .clk_mem_wb_pipe(clk), .rst_mem_wb_pipe(rst),
    .valid_IN(b_valid_in), .ready_OUT(b_ready_out),
    .data_IN(b_data_in), .resALU_IN(b_alu_in), .regDst_IN(b_rd_in), .WB_IN(b_wb_in),
    .flush_IN(b_flush), .valid_OUT(b_valid_out), .ready_IN(b_ready_in),
    .data_OUT(b_data_out), .resALU_OUT(b_alu_out), .regDst_OUT(b_rd_out),
    .RegWrite_OUT(b_rw_out), .MemtoReg_OUT(b_m2r_out), .wbValue_OUT(b_wb_out)
`ifdef MEM_WB_STALL_CNT_EN
    , .stallCount_OUT(b_cnt)
`endif
  );

`ifdef MEM_WB_STALL_CNT_EN
  mem_wb_pipe #(.DATA_W(32), .REG_W(5), .SKID(1), .CNT_W(2)) u_dut_sat (
    .clk_mem_wb_pipe(clk), .rst_mem_wb_pipe(rst),
    .valid_IN(1'b1), .ready_OUT(sat_ready_out),
    .data_IN(32'h1), .resALU_IN(32'h2), .regDst_IN(5'd1), .WB_IN(2'b10),
    .flush_IN(1'b0), .valid_OUT(sat_valid_out), .ready_IN(1'b0),
    .data_OUT(sat_data_out), .resALU_OUT(sat_alu_out), .regDst_OUT(sat_rd_out),
    .RegWrite_OUT(sat_rw_out), .MemtoReg_OUT(sat_m2r_out), .wbValue_OUT(sat_wb_out),
    .stallCount_OUT(sat_cnt)
  );
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input logic v, input logic [31:0] alu, input logic [31:0] dat,
                       input logic [4:0] rd, input logic [1:0] wb);
    a_valid_in = v;
    a_alu_in   = alu;
    a_data_in  = dat;
    a_rd_in    = rd;
    a_wb_in    = wb;
  endtask

  initial begin
    logic [31:0] vals [3];
    int          acc, dlv;
    logic        ev, exp_rdy, in_f, out_f;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    a_set(1'b0, '0, '0, '0, '0);
    a_flush = 1'b0; a_ready_in = 1'b1;
    b_valid_in = 1'b0; b_flush = 1'b0; b_ready_in = 1'b0;
    b_data_in = '0; b_alu_in = '0; b_rd_in = 5'd3; b_wb_in = 2'b10;

    step();
    step();
    rst = 1'b0;
    check_val("rst_valid", a_valid_out, 1'b0);
    check_val("rst_ready", a_ready_out, 1'b1);
    check_val("rst_data", a_data_out, 32'h0);
    check_val("rst_alu", a_alu_out, 32'h0);
    check_val("rst_rd", a_rd_out, 5'd0);
    check_val("rst_rw", a_rw_out, 1'b0);
    check_val("rst_m2r", a_m2r_out, 1'b0);
    check_val("rst_wb", a_wb_out, 32'h0);

    // Streaming with ready_IN=1
    vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30;
    for (int i = 0; i < 3; i++) begin
      a_set(1'b1, vals[i], 32'hAA, 5'd5, 2'b10);
      step();
      check_val("str_valid", a_valid_out, 1'b1);
      check_val("str_alu", a_alu_out, vals[i]);
      check_val("str_rd", a_rd_out, 5'd5);
      check_val("str_rw", a_rw_out, 1'b1);
      check_val("str_wb", a_wb_out, vals[i]);
      check_val("str_ready", a_ready_out, 1'b1);
    end
    a_valid_in = 1'b0;
    step();
    check_val("str_end_valid", a_valid_out, 1'b0);
    check_val("str_end_rw", a_rw_out, 1'b0);
    check_val("str_hold_alu", a_alu_out, 32'h30);

    // Back-pressure: fill skid, then drain in order
    a_ready_in = 1'b0;
    a_set(1'b1, 32'h11, 32'h0, 5'd6, 2'b10);
    step();
    check_val("bp_a_valid", a_valid_out, 1'b1);
    check_val("bp_a_alu", a_alu_out, 32'h11);
    check_val("bp_one_ready", a_ready_out, 1'b1);
    a_set(1'b1, 32'h22, 32'h0, 5'd6, 2'b10);
    step();
    check_val("bp_full_ready", a_ready_out, 1'b0);
    check_val("bp_full_alu", a_alu_out, 32'h11);
    a_valid_in = 1'b0;
    step();
    step();
    check_val("bp_hold_alu", a_alu_out, 32'h11);
    check_val("bp_hold_ready", a_ready_out, 1'b0);
`ifdef MEM_WB_STALL_CNT_EN
    check_val("stall_cnt3", a_cnt, 32'd3);
`endif
    a_ready_in = 1'b1;
    step();
    check_val("bp_b_valid", a_valid_out, 1'b1);
    check_val("bp_b_alu", a_alu_out, 32'h22);
    check_val("bp_ready_back", a_ready_out, 1'b1);
    step();
    check_val("bp_drained", a_valid_out, 1'b0);

    // Write to $zero is suppressed, writeback value still formed
    a_set(1'b1, 32'h55, 32'hDEAD, 5'd0, 2'b11);
    step();
    check_val("zero_valid", a_valid_out, 1'b1);
    check_val("zero_rw", a_rw_out, 1'b0);
    check_val("zero_m2r", a_m2r_out, 1'b1);
    check_val("zero_wb", a_wb_out, 32'hDEAD);
    a_valid_in = 1'b0;
    step();

    // Flush from FULL with a simultaneous valid input
    a_ready_in = 1'b0;
    a_set(1'b1, 32'h33, 32'h0, 5'd2, 2'b10);
    step();
    a_set(1'b1, 32'h44, 32'h0, 5'd2, 2'b10);
    step();
    check_val("fl_full_ready", a_ready_out, 1'b0);
    a_flush = 1'b1;
    a_set(1'b1, 32'h99, 32'h0, 5'd2, 2'b10);
    step();
    check_val("fl_valid", a_valid_out, 1'b0);
    check_val("fl_rw", a_rw_out, 1'b0);
    check_val("fl_ready", a_ready_out, 1'b1);
    a_flush = 1'b0;
    a_valid_in = 1'b0;
    a_ready_in = 1'b1;
    step();
    check_val("fl_no_leak", a_valid_out, 1'b0);
    // Flush while empty discards an accepted input
    a_flush = 1'b1;
    a_set(1'b1, 32'h77, 32'h0, 5'd2, 2'b10);
    step();
    check_val("fl_empty_valid", a_valid_out, 1'b0);
    a_flush = 1'b0;
    a_valid_in = 1'b0;
    step();
    check_val("fl_empty_after", a_valid_out, 1'b0);

    // Reset while ONE
    a_ready_in = 1'b0;
    a_set(1'b1, 32'h66, 32'hBEEF, 5'd7, 2'b11);
    step();
    check_val("rs_one_valid", a_valid_out, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_valid_in = 1'b0;
    check_val("rs_valid", a_valid_out, 1'b0);
    check_val("rs_data", a_data_out, 32'h0);
    check_val("rs_alu", a_alu_out, 32'h0);
    check_val("rs_rd", a_rd_out, 5'd0);
    check_val("rs_rw", a_rw_out, 1'b0);
    check_val("rs_wb", a_wb_out, 32'h0);
    check_val("rs_ready", a_ready_out, 1'b1);
`ifdef MEM_WB_STALL_CNT_EN
    check_val("rs_cnt", a_cnt, 32'd0);
`endif

    // SKID=0: ready_IN toggles, continuous valid, 8 entries in order
    acc = 0;
    dlv = 0;
    ev  = 1'b0;
    for (int i = 0; i < 40 && dlv < 8; i++) begin
      b_ready_in = i[0];
      b_valid_in = (acc < 8);
      b_alu_in   = 32'h100 + acc;
      #1;
      exp_rdy = b_ready_in | ~ev;
      check_val("s0_ready", b_ready_out, exp_rdy);
      check_val("s0_valid", b_valid_out, ev);
      out_f = ev & b_ready_in;
      in_f  = b_valid_in & exp_rdy;
      if (out_f) begin
        check_val("s0_order", b_alu_out, 32'h100 + dlv);
        dlv++;
      end
      if (in_f) begin
        ev = 1'b1;
        acc++;
      end else if (out_f) begin
        ev = 1'b0;
      end
      step();
    end
    check_val("s0_delivered", dlv, 32'd8);
    check_val("s0_accepted", acc, 32'd8);

`ifdef MEM_WB_STALL_CNT_EN
    check_val("sat_cnt", sat_cnt, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
